// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 key event decoder.
// Covers byte values, special codes, parser states and the event record.
package ps2_pkg;

    localparam logic [7:0] BAT_OK    = 8'hAA;
    localparam logic [7:0] BAT_FAIL  = 8'hFC;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    localparam logic [8:0] PAUSE_CODE  = 9'h1E1;
    localparam logic [8:0] FAKE_LSHIFT = 9'h112;
    localparam logic [8:0] FAKE_RSHIFT = 9'h159;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        UNSYNC,
        IDLE,
        EXT,
        BRK,
        EXTBRK,
        PAUSE
    } parse_state_t;

    typedef struct packed {
        logic [8:0] code;
        logic       make;
        logic       rpt;
    } key_event_t;

    typedef struct packed {
        logic       vld;
        logic       pause;
        logic       clr;
        logic [8:0] code;
        logic       make;
    } parse_out_t;

    function automatic logic is_fake_shift(input logic [8:0] c);
        return (c == FAKE_LSHIFT) || (c == FAKE_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with occupancy count.
// Head is read straight from the storage registers, so a write into an empty FIFO is visible next cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign do_rd = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 scan-code parser with held-key bitmap and queued make/break events.
// Stage 1 parses bytes into candidate events; stage 2 applies them to the bitmap and FIFO.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter bit REPEAT_EN       = 1'b0,
    parameter bit DROP_FAKE_SHIFT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   byte_err,
    input  logic                   ev_ready,
    input  logic                   ovf_clr,
    output logic                   ev_valid,
    output logic [8:0]             ev_code,
    output logic                   ev_make,
    output logic                   ev_repeat,
    output logic [511:0]           key_down,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   overflow,
    output logic                   sync_ok
);

    parse_state_t state;
    parse_state_t state_d;
    logic [2:0]   skip;
    logic [2:0]   skip_d;
    logic         sync_d;
    parse_out_t   p_d;
    parse_out_t   p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= UNSYNC;
            skip    <= '0;
            sync_ok <= 1'b0;
            p_q     <= '0;
        end else begin
            state   <= state_d;
            skip    <= skip_d;
            sync_ok <= sync_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state;
        skip_d  = skip;
        sync_d  = sync_ok;
        p_d     = '0;
        if (byte_err) begin
            if (state != UNSYNC) begin
                state_d = IDLE;
            end
            skip_d = '0;
        end else if (byte_valid) begin
            unique case (state)
                UNSYNC: begin
                    if (byte_data == BAT_OK) begin
                        state_d = IDLE;
                        sync_d  = 1'b1;
                    end
                end
                IDLE: begin
                    unique case (1'b1)
                        (byte_data == PFX_EXT):   state_d = EXT;
                        (byte_data == PFX_BRK):   state_d = BRK;
                        (byte_data == PFX_PAUSE): begin
                            state_d = PAUSE;
                            skip_d  = PAUSE_SKIP;
                        end
                        (byte_data == BAT_OK):    p_d.clr = 1'b1;
                        (byte_data == BAT_FAIL):  begin
                            state_d = UNSYNC;
                            sync_d  = 1'b0;
                        end
                        default: begin
                            p_d.vld  = 1'b1;
                            p_d.code = {1'b0, byte_data};
                            p_d.make = 1'b1;
                        end
                    endcase
                end
                EXT: begin
                    if (byte_data == PFX_BRK) begin
                        state_d = EXTBRK;
                    end else begin
                        state_d  = IDLE;
                        p_d.vld  = 1'b1;
                        p_d.code = {1'b1, byte_data};
                        p_d.make = 1'b1;
                    end
                end
                BRK: begin
                    state_d  = IDLE;
                    p_d.vld  = 1'b1;
                    p_d.code = {1'b0, byte_data};
                end
                EXTBRK: begin
                    state_d  = IDLE;
                    p_d.vld  = 1'b1;
                    p_d.code = {1'b1, byte_data};
                end
                PAUSE: begin
                    skip_d = skip - 3'd1;
                    if (skip == 3'd1) begin
                        state_d   = IDLE;
                        p_d.vld   = 1'b1;
                        p_d.pause = 1'b1;
                        p_d.code  = PAUSE_CODE;
                        p_d.make  = 1'b1;
                    end
                end
                default: state_d = UNSYNC;
            endcase
            if (DROP_FAKE_SHIFT && p_d.vld && !p_d.pause
                && is_fake_shift(p_d.code)) begin
                p_d.vld = 1'b0;
            end
        end
    end

    logic       hit;
    logic       is_rpt;
    logic       push;
    logic       pop;
    logic       bm_wr;
    logic       drop;
    logic       fifo_full;
    logic       fifo_empty;
    key_event_t wr_ev;
    key_event_t head;

    // Pause carries no bitmap state, so it is never a repeat.
    assign hit    = key_down[p_q.code];
    assign is_rpt = p_q.vld && !p_q.pause && p_q.make && hit;
    assign push   = p_q.vld && (!is_rpt || REPEAT_EN);
    assign bm_wr  = p_q.vld && !p_q.pause && !is_rpt;
    assign pop    = ev_valid && ev_ready;
    assign drop   = push && fifo_full && !pop;

    always_comb begin
        wr_ev      = '0;
        wr_ev.code = p_q.code;
        wr_ev.make = p_q.make;
        wr_ev.rpt  = is_rpt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_down <= '0;
            overflow <= 1'b0;
        end else begin
            if (p_q.clr) begin
                key_down <= '0;
            end else if (bm_wr) begin
                key_down[p_q.code] <= p_q.make;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(key_event_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_ev),
        .rd_en   (pop),
        .rd_data (head),
        .count   (ev_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid  = !fifo_empty;
    assign ev_code   = head.code;
    assign ev_make   = head.make;
    assign ev_repeat = head.rpt;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: vector table, directed corner sequences,
// then random byte streams against a sequential reference model.
module tb_ps2_key_event_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;
    logic       ev_ready;
    logic       ovf_clr;

    logic         a_valid, a_make, a_rep, a_ovf, a_sync;
    logic [8:0]   a_code;
    logic [511:0] a_kd;
    logic [2:0]   a_count;

    logic         b_valid, b_make, b_rep, b_ovf, b_sync;
    logic [8:0]   b_code;
    logic [511:0] b_kd;
    logic [3:0]   b_count;

    ps2_key_event_decoder #(
        .DEPTH(4), .REPEAT_EN(1'b0), .DROP_FAKE_SHIFT(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_err(byte_err),
        .ev_ready(ev_ready), .ovf_clr(ovf_clr),
        .ev_valid(a_valid), .ev_code(a_code), .ev_make(a_make),
        .ev_repeat(a_rep), .key_down(a_kd), .ev_count(a_count),
        .overflow(a_ovf), .sync_ok(a_sync)
    );

    ps2_key_event_decoder #(
        .DEPTH(8), .REPEAT_EN(1'b1), .DROP_FAKE_SHIFT(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_err(byte_err),
        .ev_ready(ev_ready), .ovf_clr(ovf_clr),
        .ev_valid(b_valid), .ev_code(b_code), .ev_make(b_make),
        .ev_repeat(b_rep), .key_down(b_kd), .ev_count(b_count),
        .overflow(b_ovf), .sync_ok(b_sync)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] ev(input logic [8:0] c,
                                       input logic mk, input logic rp);
        return {c, mk, rp};
    endfunction

    // Reference model: one per instance, driven by the same byte stream.
    bit [511:0]  m_kd   [2];
    bit          m_sync [2];
    bit          m_ext  [2];
    bit          m_brk  [2];
    int          m_skip [2];
    bit          m_ovf  [2];
    logic [10:0] q0[$];
    logic [10:0] q1[$];

    function automatic void m_reset();
        for (int m = 0; m < 2; m++) begin
            m_kd[m] = '0; m_sync[m] = 0; m_ext[m] = 0;
            m_brk[m] = 0; m_skip[m] = 0; m_ovf[m] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void m_push(input int m, input logic [10:0] e);
        if (m == 0) begin
            if (q0.size() >= 4) m_ovf[0] = 1;
            else q0.push_back(e);
        end else begin
            if (q1.size() >= 8) m_ovf[1] = 1;
            else q1.push_back(e);
        end
    endfunction

    function automatic void m_key(input int m, input logic [8:0] code,
                                  input bit make);
        bit drop_fs = (m == 0);
        bit rep_en  = (m == 1);
        if (drop_fs && (code == 9'h112 || code == 9'h159)) return;
        if (make) begin
            if (m_kd[m][code]) begin
                if (rep_en) m_push(m, ev(code, 1'b1, 1'b1));
            end else begin
                m_kd[m][code] = 1'b1;
                m_push(m, ev(code, 1'b1, 1'b0));
            end
        end else begin
            m_kd[m][code] = 1'b0;
            m_push(m, ev(code, 1'b0, 1'b0));
        end
    endfunction

    function automatic void m_byte(input int m, input logic [7:0] b);
        if (!m_sync[m]) begin
            if (b == 8'hAA) m_sync[m] = 1;
            return;
        end
        if (m_skip[m] > 0) begin
            m_skip[m]--;
            if (m_skip[m] == 0) m_push(m, ev(9'h1E1, 1'b1, 1'b0));
            return;
        end
        if (!m_ext[m] && !m_brk[m]) begin
            if (b == 8'hE0) begin m_ext[m] = 1; return; end
            if (b == 8'hF0) begin m_brk[m] = 1; return; end
            if (b == 8'hE1) begin m_skip[m] = 7; return; end
            if (b == 8'hAA) begin m_kd[m] = '0; return; end
            if (b == 8'hFC) begin m_sync[m] = 0; return; end
        end else if (m_ext[m] && !m_brk[m] && b == 8'hF0) begin
            m_brk[m] = 1;
            return;
        end
        m_key(m, {m_ext[m], b}, !m_brk[m]);
        m_ext[m] = 0;
        m_brk[m] = 0;
    endfunction

    function automatic void m_err(input int m);
        if (m_sync[m]) begin
            m_ext[m] = 0; m_brk[m] = 0; m_skip[m] = 0;
        end
    endfunction

    // All drive tasks start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        m_byte(0, b);
        m_byte(1, b);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic err_strobe();
        byte_err = 1'b1;
        m_err(0);
        m_err(1);
        @(negedge clk);
        byte_err = 1'b0;
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        idle(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [9:0][7:0]  b;
        int               len;
        int               n_ev;
        logic [2:0][10:0] evs;
        logic [8:0]       kd_idx;
        logic             kd_val;
        bit               kd_zero;
    } vec_t;

    vec_t vt [10];

    function automatic logic [7:0] pick(input int r);
        logic [7:0] codes [7];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h75, 8'h6B};
        case (r)
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return 8'hE1;
            5:       return 8'hAA;
            6:       return 8'hFC;
            8:       return 8'h12;
            9:       return 8'h59;
            default: return codes[r % 7];
        endcase
    endfunction

    initial begin
        logic [8:0] five [5];
        logic [10:0] rexp [3];
        int n;

        rst = 1'b1; byte_valid = 1'b0; byte_data = '0;
        byte_err = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
        m_reset();

        vt[0] = '{b: {8'h1C, 8'hF0, 8'h1C, {7{8'h00}}}, len: 3, n_ev: 2,
                  evs: {ev(9'h01C, 1'b1, 1'b0), ev(9'h01C, 1'b0, 1'b0), 11'h0},
                  kd_idx: 9'h01C, kd_val: 1'b0, kd_zero: 1'b1};
        vt[1] = '{b: {8'h1C, {9{8'h00}}}, len: 1, n_ev: 1,
                  evs: {ev(9'h01C, 1'b1, 1'b0), 22'h0},
                  kd_idx: 9'h01C, kd_val: 1'b1, kd_zero: 1'b0};
        vt[2] = '{b: {8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                      {3{8'h00}}}, len: 7, n_ev: 2,
                  evs: {ev(9'h175, 1'b1, 1'b0), ev(9'h175, 1'b0, 1'b0), 11'h0},
                  kd_idx: 9'h175, kd_val: 1'b0, kd_zero: 1'b1};
        vt[3] = '{b: {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0,
                      8'h77, {2{8'h00}}}, len: 8, n_ev: 1,
                  evs: {ev(9'h1E1, 1'b1, 1'b0), 22'h0},
                  kd_idx: 9'h1E1, kd_val: 1'b0, kd_zero: 1'b1};
        vt[4] = '{b: {8'hE0, 8'h12, {8{8'h00}}}, len: 2, n_ev: 0,
                  evs: 33'h0,
                  kd_idx: 9'h112, kd_val: 1'b0, kd_zero: 1'b1};
        vt[5] = '{b: {8'hE0, 8'hF0, 8'h59, 8'h1C, {6{8'h00}}}, len: 4, n_ev: 1,
                  evs: {ev(9'h01C, 1'b1, 1'b0), 22'h0},
                  kd_idx: 9'h01C, kd_val: 1'b1, kd_zero: 1'b0};
        vt[6] = '{b: {8'hF0, 8'h33, {8{8'h00}}}, len: 2, n_ev: 1,
                  evs: {ev(9'h033, 1'b0, 1'b0), 22'h0},
                  kd_idx: 9'h033, kd_val: 1'b0, kd_zero: 1'b1};
        vt[7] = '{b: {8'h1C, 8'hAA, {8{8'h00}}}, len: 2, n_ev: 1,
                  evs: {ev(9'h01C, 1'b1, 1'b0), 22'h0},
                  kd_idx: 9'h01C, kd_val: 1'b0, kd_zero: 1'b1};
        vt[8] = '{b: {8'h1C, 8'h1C, 8'h1C, {7{8'h00}}}, len: 3, n_ev: 1,
                  evs: {ev(9'h01C, 1'b1, 1'b0), 22'h0},
                  kd_idx: 9'h01C, kd_val: 1'b1, kd_zero: 1'b0};
        vt[9] = '{b: {8'hE0, 8'h1C, 8'h1C, 8'hF0, 8'h1C, {5{8'h00}}},
                  len: 5, n_ev: 3,
                  evs: {ev(9'h11C, 1'b1, 1'b0), ev(9'h01C, 1'b1, 1'b0),
                        ev(9'h01C, 1'b0, 1'b0)},
                  kd_idx: 9'h11C, kd_val: 1'b1, kd_zero: 1'b0};

        idle(2);
        rst = 1'b0;

        // Reset values
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_code", {a_code, a_make, a_rep}, 11'h0);
        chk("rst_kd", a_kd, 512'h0);
        chk("rst_count", a_count, 3'd0);
        chk("rst_ovf", a_ovf, 1'b0);
        chk("rst_sync", a_sync, 1'b0);
        chk("rst_b_all", {b_valid, b_code, b_make, b_rep, b_count,
                          b_ovf, b_sync}, 20'h0);
        chk("rst_b_kd", b_kd, 512'h0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            send(8'hAA);
            for (int j = 0; j < vt[i].len; j++) send(vt[i].b[9-j]);
            idle(3);
            chk($sformatf("vec%0d_count", i), a_count, vt[i].n_ev);
            chk($sformatf("vec%0d_kdbit", i), a_kd[vt[i].kd_idx], vt[i].kd_val);
            if (vt[i].kd_zero) chk($sformatf("vec%0d_kdzero", i), a_kd, 512'h0);
            for (int k = 0; k < vt[i].n_ev; k++) begin
                chk($sformatf("vec%0d_valid%0d", i, k), a_valid, 1'b1);
                chk($sformatf("vec%0d_ev%0d", i, k), {a_code, a_make, a_rep},
                    vt[i].evs[2-k]);
                pop();
            end
            chk($sformatf("vec%0d_drained", i), a_valid, 1'b0);
        end

        // Unsynced bytes are ignored; BAT then syncs
        do_reset();
        send(8'h1C);
        send(8'h32);
        idle(3);
        chk("unsync_count", a_count, 3'd0);
        chk("unsync_sync", a_sync, 1'b0);
        send(8'hAA);
        chk("bat_sync", a_sync, 1'b1);

        // Two-cycle byte-to-event latency
        send(8'h1C);
        chk("lat_n1", a_valid, 1'b0);
        idle(1);
        chk("lat_n2", a_valid, 1'b1);
        chk("lat_code", {a_code, a_make, a_rep}, ev(9'h01C, 1'b1, 1'b0));

        // byte_err drops a pending E0 prefix
        do_reset();
        send(8'hAA);
        send(8'hE0);
        err_strobe();
        send(8'h1C);
        idle(2);
        chk("err_count", a_count, 3'd1);
        chk("err_code", {a_code, a_make, a_rep}, ev(9'h01C, 1'b1, 1'b0));

        // Mid-sequence reset loses the prefix and unsyncs at once
        do_reset();
        send(8'hAA);
        send(8'hE0);
        rst = 1'b1;
        #1;
        chk("midrst_sync", a_sync, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hAA);
        send(8'h75);
        idle(2);
        chk("midrst_code", {a_valid, a_code, a_make, a_rep},
            {1'b1, ev(9'h075, 1'b1, 1'b0)});

        // Repeat classification on the REPEAT_EN instance
        do_reset();
        send(8'hAA);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(3);
        chk("rep_b_count", b_count, 4'd3);
        chk("rep_a_count", a_count, 3'd2);
        rexp = '{ev(9'h175, 1'b1, 1'b0), ev(9'h175, 1'b1, 1'b1),
                 ev(9'h175, 1'b0, 1'b0)};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rep_b_ev%0d", k), {b_code, b_make, b_rep}, rexp[k]);
            pop();
        end

        // Overflow on the 4-deep instance
        do_reset();
        send(8'hAA);
        five = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024};
        for (int k = 0; k < 5; k++) send(five[k][7:0]);
        idle(3);
        chk("ovf_count", a_count, 3'd4);
        chk("ovf_flag", a_ovf, 1'b1);
        chk("ovf_b_count", b_count, 4'd5);
        chk("ovf_b_flag", b_ovf, 1'b0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("ovf_kd%0d", k), a_kd[five[k]], 1'b1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", a_ovf, 1'b0);
        send(8'h2B);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", a_ovf, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_pop%0d", k), {a_valid, a_code},
                {1'b1, five[k]});
            pop();
        end
        chk("ovf_empty", a_valid, 1'b0);

        // Push and pop in the same cycle while full
        do_reset();
        send(8'hAA);
        for (int k = 0; k < 4; k++) send(five[k][7:0]);
        idle(3);
        chk("pp_full", a_count, 3'd4);
        send(8'h24);
        pop();
        chk("pp_count", a_count, 3'd4);
        chk("pp_ovf", a_ovf, 1'b0);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("pp_pop%0d", k), {a_valid, a_code},
                {1'b1, five[k]});
            pop();
        end

        // Pop request while empty does not eat the incoming event
        do_reset();
        send(8'hAA);
        send(8'h1C);
        pop();
        chk("pe_count", a_count, 3'd1);
        chk("pe_code", a_code, 9'h01C);

        // Random streams against the model
        do_reset();
        send(8'hAA);
        for (int burst = 0; burst < 40; burst++) begin
            ovf_clr = 1'b1;
            m_ovf[0] = 0;
            m_ovf[1] = 0;
            idle(1);
            ovf_clr = 1'b0;
            n = $urandom_range(1, 14);
            for (int j = 0; j < n; j++) begin
                int r = int'($urandom_range(0, 31));
                if (r == 7) err_strobe();
                else send(pick(r));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(3);
            chk($sformatf("rnd%0d_a_count", burst), a_count, q0.size());
            chk($sformatf("rnd%0d_b_count", burst), b_count, q1.size());
            chk($sformatf("rnd%0d_a_ovf", burst), a_ovf, m_ovf[0]);
            chk($sformatf("rnd%0d_b_ovf", burst), b_ovf, m_ovf[1]);
            chk($sformatf("rnd%0d_a_kd", burst), a_kd, m_kd[0]);
            chk($sformatf("rnd%0d_b_kd", burst), b_kd, m_kd[1]);
            chk($sformatf("rnd%0d_a_sync", burst), a_sync, m_sync[0]);
            chk($sformatf("rnd%0d_b_sync", burst), b_sync, m_sync[1]);
            n = (q0.size() > q1.size()) ? q0.size() : q1.size();
            for (int k = 0; k < n; k++) begin
                if (q0.size() > 0)
                    chk($sformatf("rnd%0d_a_ev%0d", burst, k),
                        {a_valid, a_code, a_make, a_rep}, {1'b1, q0[0]});
                if (q1.size() > 0)
                    chk($sformatf("rnd%0d_b_ev%0d", burst, k),
                        {b_valid, b_code, b_make, b_rep}, {1'b1, q1[0]});
                pop();
            end
            chk($sformatf("rnd%0d_drained", burst), {a_valid, b_valid}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
